mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares a single-ported unified memory between the IF-stage instruction fetch and the MEM-stage data access.
- Arbitrates requests, locks each grant until the downstream handshake completes, and tracks one outstanding transaction.
- Routes the response back to the requester that owns it.
- Sits between `if_stage`/`mem_stage` and the memory model or bus; its ready/valid signals feed the hazard unit's stall logic.

Parameters:
- RESET_OWNER, 1'b0, owner register value after reset (0 = imem, 1 = dmem); affects only `o_owner`.
- STARVE_LIMIT, 4, maximum consecutive dmem grants while imem is pending (used only with the optional feature); legal range 1..15.

Ports:
- i_clk  in  1  global clock
- i_rst_n  in  1  asynchronous active-low reset
- i_imem_valid  in  1  fetch request
- o_imem_ready  out  1  fetch request accepted
- i_imem_addr  in  32  fetch address
- o_imem_rvalid  out  1  fetch data valid
- o_imem_rdata  out  32  fetch data
- i_dmem_valid  in  1  data request
- o_dmem_ready  out  1  data request accepted
- i_dmem_addr  in  32  data address
- i_dmem_wen  in  1  1 = store, 0 = load
- i_dmem_wdata  in  32  store data
- i_dmem_mask  in  4  byte enables
- o_dmem_rvalid  out  1  load data / store ack valid
- o_dmem_rdata  out  32  load data
- o_mem_valid  out  1  downstream request
- i_mem_ready  in  1  downstream accepts request
- o_mem_addr  out  32  downstream address, bits [1:0] forced to 0
- o_mem_wen  out  1  downstream write enable (always 0 for imem)
- o_mem_wdata  out  32  downstream write data (0 for imem)
- o_mem_mask  out  4  downstream byte enables (4'hF for imem)
- i_mem_rvalid  in  1  downstream response (asserted for loads and stores)
- i_mem_rdata  in  32  downstream read data
- o_owner  out  1  current/last owner (0 = imem, 1 = dmem)
- o_busy  out  1  state != IDLE

Behaviour:
- Interface: one clock `i_clk`; reset `i_rst_n` is asynchronous and active-low.
- FSM states: IDLE, HOLD, WAIT_RSP.
- Reset:
  - state = IDLE, owner = RESET_OWNER, starvation counter = 0.
  - While `i_rst_n` is low, all valid/ready outputs are 0 and data outputs are 0.
- IDLE:
  - Grant is combinational: dmem if `i_dmem_valid`, else imem if `i_imem_valid`.
  - `o_mem_valid` = either request; the payload is muxed from the granted requester.
  - Handshake (`o_mem_valid && i_mem_ready`): the granted requester's ready = 1 in the same cycle, owner <= grant, next state WAIT_RSP.
  - Request present but `i_mem_ready` = 0: owner <= grant, next state HOLD.
- HOLD:
  - Grant is frozen to owner; the payload comes from owner regardless of the other requester.
  - The owner's valid stays high and its payload stable until its ready (requester contract, not checked).
  - On `i_mem_ready`: owner's ready = 1, next state WAIT_RSP.
- WAIT_RSP:
  - `o_mem_valid` = 0 and both readies = 0.
  - On `i_mem_rvalid`: the owner's rvalid = 1 and rdata = `i_mem_rdata` (combinational pass-through); next state IDLE.
  - The non-owner's rvalid stays 0.
- Throughput:
  - One outstanding transaction.
  - Minimum 2 cycles per transaction (request cycle + response cycle); no issue in the response cycle.
- Unexpected inputs:
  - `i_mem_rvalid` in IDLE or HOLD is ignored.
  - `i_mem_ready` in WAIT_RSP is ignored.
- Reset mid-transaction:
  - FSM returns to IDLE immediately and any outstanding response is dropped.
  - Requesters must re-issue the request.
- `o_mem_addr` = selected address & 32'hFFFF_FFFC.
- `o_owner` = owner register in HOLD/WAIT_RSP and the combinational grant in IDLE.

Optional Feature:
- Macro: `MEM_ARB_STARVE_GUARD_EN`.
- With the macro defined:
  - A 4-bit counter increments on each dmem handshake while `i_imem_valid` = 1.
  - The counter clears on any imem handshake, or on any handshake while `i_imem_valid` = 0.
  - When the counter equals STARVE_LIMIT and `i_imem_valid` = 1, the IDLE grant goes to imem even if dmem is valid.
- Without the macro: strict dmem priority, no counter logic is synthesised, and the counter reads as 0.

Test Plan:
- Solo fetch, imem addr 32'h0000_0102 with `i_mem_ready` = 1 → cycle 0: `o_mem_addr` = 32'h0000_0100, `o_imem_ready` = 1, mask F, wen 0; next cycle `i_mem_rvalid` with rdata 32'h0010_0093 → `o_imem_rvalid` = 1 with that data, `o_dmem_rvalid` = 0.
- Simultaneous imem and dmem store (addr 0x2000, wdata 0xDEAD_BEEF, mask 4'h3) → dmem granted first with wen 1 and mask 3; imem is granted in the IDLE cycle after the dmem response.
- Hold: imem valid with `i_mem_ready` low for 3 cycles, dmem asserted in the 2nd cycle → `o_mem_addr` stays on the imem address and `o_owner` = 0 until ready; dmem is served next.
- Async reset: drop `i_rst_n` in WAIT_RSP between clock edges → `o_busy` = 0 and all valid/ready outputs go 0 immediately; a later stray `i_mem_rvalid` produces no rvalid.
- With `MEM_ARB_STARVE_GUARD_EN` and STARVE_LIMIT = 4, dmem and imem both continuously valid → grant pattern D,D,D,D,I repeating; without the macro, imem is never granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (imem) and data access (dmem).
// Optional starvation guard for imem is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter logic RESET_OWNER  = 1'b0,
  parameter int   STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_imem_valid,
  output logic        o_imem_ready,
  input  logic [31:0] i_imem_addr,
  output logic        o_imem_rvalid,
  output logic [31:0] o_imem_rdata,
  input  logic        i_dmem_valid,
  output logic        o_dmem_ready,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_rvalid,
  output logic [31:0] o_dmem_rdata,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_owner,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_owner;
  logic [3:0]  w_starve_cnt;
  logic        w_any_req;
  logic        w_force_imem;
  logic        w_grant;
  logic        w_sel;
  logic        w_issue;
  logic        w_hs;
  logic        w_rsp;
  logic [31:0] w_addr;

  assign w_any_req = i_imem_valid | i_dmem_valid;

  // The counter is constant zero when the guard is compiled out, so with
  // STARVE_LIMIT >= 1 this never forces imem and dmem keeps strict priority.
  assign w_force_imem = i_imem_valid && (w_starve_cnt == 4'(STARVE_LIMIT));

  // With no request pending the grant keeps pointing at the last owner.
  assign w_grant = w_force_imem ? 1'b0 :
                   i_dmem_valid ? 1'b1 :
                   i_imem_valid ? 1'b0 : r_owner;

  assign w_sel   = (r_state == S_IDLE) ? w_grant : r_owner;

  assign w_issue = i_rst_n && (((r_state == S_IDLE) && w_any_req) || (r_state == S_HOLD));
  assign w_hs    = w_issue && i_mem_ready;
  assign w_rsp   = i_rst_n && (r_state == S_WAIT_RSP) && i_mem_rvalid;

  assign w_addr  = w_sel ? i_dmem_addr : i_imem_addr;

  assign o_mem_valid   = w_issue;
  assign o_imem_ready  = w_hs && !w_sel;
  assign o_dmem_ready  = w_hs &&  w_sel;
  assign o_mem_addr    = i_rst_n ? (w_addr & 32'hFFFF_FFFC) : 32'h0;
  assign o_mem_wen     = i_rst_n && w_sel && i_dmem_wen;
  assign o_mem_wdata   = (i_rst_n && w_sel) ? i_dmem_wdata : 32'h0;
  assign o_mem_mask    = !i_rst_n ? 4'h0 : (w_sel ? i_dmem_mask : 4'hF);

  assign o_imem_rvalid = w_rsp && !r_owner;
  assign o_dmem_rvalid = w_rsp &&  r_owner;
  assign o_imem_rdata  = o_imem_rvalid ? i_mem_rdata : 32'h0;
  assign o_dmem_rdata  = o_dmem_rvalid ? i_mem_rdata : 32'h0;

  assign o_owner = (i_rst_n && (r_state == S_IDLE)) ? w_grant : r_owner;
  assign o_busy  = (r_state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_owner <= RESET_OWNER;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant;
            r_state <= i_mem_ready ? S_WAIT_RSP : S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_mem_ready) r_state <= S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          if (i_mem_rvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] r_starve_cnt;

  // Counts back-to-back dmem wins over a waiting imem; any other handshake resets it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (w_hs) begin
      if (w_sel && i_imem_valid) r_starve_cnt <= r_starve_cnt + 4'd1;
      else                       r_starve_cnt <= 4'd0;
    end
  end

  assign w_starve_cnt = r_starve_cnt;
`else
  assign w_starve_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter: cycle traces plus reset and priority sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_valid, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_valid, dmem_ready, dmem_wen, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_mask;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;
  logic        owner, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_imem_valid(imem_valid), .o_imem_ready(imem_ready), .i_imem_addr(imem_addr),
    .o_imem_rvalid(imem_rvalid), .o_imem_rdata(imem_rdata),
    .i_dmem_valid(dmem_valid), .o_dmem_ready(dmem_ready), .i_dmem_addr(dmem_addr),
    .i_dmem_wen(dmem_wen), .i_dmem_wdata(dmem_wdata), .i_dmem_mask(dmem_mask),
    .o_dmem_rvalid(dmem_rvalid), .o_dmem_rdata(dmem_rdata),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
    .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_owner(owner), .o_busy(busy)
  );

  // Packed order: mem_valid, addr, wen, wdata, mask, iready, dready, irvalid, irdata, drvalid, drdata, owner, busy
  function automatic logic [139:0] E(logic mv, logic [31:0] a, logic w, logic [31:0] wd, logic [3:0] m,
                                     logic ir, logic dr, logic irv, logic [31:0] ird,
                                     logic drv, logic [31:0] drd, logic own, logic bsy);
    return {mv, a, w, wd, m, ir, dr, irv, ird, drv, drd, own, bsy};
  endfunction

  function automatic logic [139:0] actual();
    return {mem_valid, mem_addr, mem_wen, mem_wdata, mem_mask, imem_ready, dmem_ready,
            imem_rvalid, imem_rdata, dmem_rvalid, dmem_rdata, owner, busy};
  endfunction

  task automatic check(input string name, input logic [139:0] act, input logic [139:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic        wen;
    logic [31:0] wd;
    logic [3:0]  mk;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic [139:0] exp;
  } vec_t;

  vec_t v[15];

  task automatic drive(input vec_t x);
    imem_valid = x.iv;  imem_addr  = x.ia;
    dmem_valid = x.dv;  dmem_addr  = x.da;  dmem_wen = x.wen;
    dmem_wdata = x.wd;  dmem_mask  = x.mk;
    mem_ready  = x.rdy; mem_rvalid = x.rv;  mem_rdata = x.rd;
  endtask

  int  grants;
  logic got_d;

  initial begin
    // Trace: idle, solo fetch, store-vs-fetch priority, hold with late dmem, load, idle-after-dmem
    v[0]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0,
              E(0, 32'h0,    0, 32'h0,        4'hF, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0)};
    v[1]  = '{1'b1, 32'h102, 1'b0, 32'h0,    1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0,
              E(1, 32'h100,  0, 32'h0,        4'hF, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0)};
    v[2]  = '{1'b0, 32'h102, 1'b0, 32'h0,    1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0010_0093,
              E(0, 32'h100,  0, 32'h0,        4'hF, 0, 0, 1, 32'h0010_0093, 0, 32'h0,       0, 1)};
    v[3]  = '{1'b1, 32'h207, 1'b1, 32'h2000, 1'b1, 32'hDEAD_BEEF, 4'h3, 1'b1, 1'b0, 32'h0,
              E(1, 32'h2000, 1, 32'hDEAD_BEEF, 4'h3, 0, 1, 0, 32'h0,       0, 32'h0,        1, 0)};
    v[4]  = '{1'b1, 32'h207, 1'b0, 32'h0,    1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'h1111_2222,
              E(0, 32'h0,    0, 32'h0,        4'h0, 0, 0, 0, 32'h0,        1, 32'h1111_2222, 1, 1)};
    v[5]  = '{1'b1, 32'h207, 1'b0, 32'h0,    1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0,
              E(1, 32'h204,  0, 32'h0,        4'hF, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0)};
    v[6]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'hCAFE_0001,
              E(0, 32'h0,    0, 32'h0,        4'hF, 0, 0, 1, 32'hCAFE_0001, 0, 32'h0,       0, 1)};
    v[7]  = '{1'b1, 32'h300, 1'b0, 32'h0,    1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
              E(1, 32'h300,  0, 32'h0,        4'hF, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0)};
    v[8]  = '{1'b1, 32'h300, 1'b1, 32'h400,  1'b0, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0000_5555,
              E(1, 32'h300,  0, 32'h0,        4'hF, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1)};
    v[9]  = '{1'b1, 32'h300, 1'b1, 32'h400,  1'b0, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0,
              E(1, 32'h300,  0, 32'h0,        4'hF, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1)};
    v[10] = '{1'b1, 32'h300, 1'b1, 32'h400,  1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0,
              E(1, 32'h300,  0, 32'h0,        4'hF, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1)};
    v[11] = '{1'b0, 32'h0,   1'b1, 32'h400,  1'b0, 32'h0,        4'hF, 1'b1, 1'b1, 32'h0BAD_F00D,
              E(0, 32'h0,    0, 32'h0,        4'hF, 0, 0, 1, 32'h0BAD_F00D, 0, 32'h0,       0, 1)};
    v[12] = '{1'b0, 32'h0,   1'b1, 32'h401,  1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0,
              E(1, 32'h400,  0, 32'h0,        4'hF, 0, 1, 0, 32'h0,        0, 32'h0,        1, 0)};
    v[13] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'h1234_5678,
              E(0, 32'h0,    0, 32'h0,        4'h0, 0, 0, 0, 32'h0,        1, 32'h1234_5678, 1, 1)};
    v[14] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
              E(0, 32'h0,    0, 32'h0,        4'h0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0)};

    // Reset with both requesters active: everything quiet, owner at its reset value
    rst_n = 1'b0;
    imem_valid = 1'b1; imem_addr = 32'h104; dmem_valid = 1'b1; dmem_addr = 32'h2000;
    dmem_wen = 1'b1; dmem_wdata = 32'hFFFF_FFFF; dmem_mask = 4'hF;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
    repeat (2) @(negedge clk);
    check("reset_outputs", actual(), E(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(v[0]);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drive(v[i]);
      @(negedge clk);
      check($sformatf("trace_row%0d", i), actual(), v[i].exp);
    end

    // Asynchronous reset while waiting for a load response
    @(posedge clk); #1;
    imem_valid = 1'b0; dmem_valid = 1'b1; dmem_addr = 32'h500; dmem_wen = 1'b0;
    dmem_mask = 4'hF; mem_ready = 1'b1; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    check1("rst_pre_busy", busy, 1'b1);
    imem_valid = 1'b1; mem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check1("rst_async_busy", busy, 1'b0);
    check("rst_async_outputs", actual(), E(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    imem_valid = 1'b0; dmem_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check1("stray_rvalid_imem", imem_rvalid, 1'b0);
    check1("stray_rvalid_dmem", dmem_rvalid, 1'b0);
    check1("post_rst_owner", owner, 1'b0);
    @(posedge clk); #1;
    check1("post_rst_idle", busy, 1'b0);
    mem_rvalid = 1'b0;

    // Both requesters continuously valid: record the grant sequence
    @(posedge clk); #1;
    imem_valid = 1'b1; imem_addr = 32'h600; dmem_valid = 1'b1; dmem_addr = 32'h700;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0;
    grants = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (imem_ready || dmem_ready) begin
        got_d = dmem_ready;
`ifdef MEM_ARB_STARVE_GUARD_EN
        check1($sformatf("starve_grant%0d_is_dmem", grants), got_d, (grants % 5) != 4);
`else
        check1($sformatf("prio_grant%0d_is_dmem", grants), got_d, 1'b1);
`endif
        grants++;
      end
    end
    n_checks++;
    if (grants != 10) begin
      n_fail++;
      $display("FAIL grant_count: got %0d expected 10", grants);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
